// File: rtl/csla_mw_seq.sv
// Multi-word adder sequencer: one 32-bit carry-select adder stepped over WORDS words, LSW first.
// Optional feature macro: CSLA_SEQ_SUB_EN adds the sub port (A - B as A + ~B + 1).

module csla_mw_seq_csla (
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] s,
    output logic        cout
);
    logic [8:0] c;
    logic [4:0] r0;
    logic [4:0] r1;

    // 4-bit blocks each precompute both carry-in cases; the incoming carry only selects.
    always_comb begin
        c    = '0;
        s    = '0;
        r0   = '0;
        r1   = '0;
        for (int k = 0; k < 8; k++) begin
            r0         = {1'b0, x[4*k +: 4]} + {1'b0, y[4*k +: 4]};
            r1         = {1'b0, x[4*k +: 4]} + {1'b0, y[4*k +: 4]} + 5'd1;
            s[4*k +: 4] = c[k] ? r1[3:0] : r0[3:0];
            c[k+1]     = c[k] ? r1[4] : r0[4];
        end
        cout = c[8];
    end
endmodule

module csla_mw_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
`ifdef CSLA_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  busy
);
    localparam int W  = 32 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, CIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q, tc_q, cout_q;
    logic [31:0]     tmp_q;
    logic [31:0]     ax, ay, as;
    logic            aco;
    logic            in_xfer, last, sub_w;

`ifdef CSLA_SEQ_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    assign in_xfer = in_valid && in_ready;
    assign last    = (idx_q == IW'(WORDS - 1));
    assign sum     = sum_q;
    assign cout    = cout_q;

    csla_mw_seq_csla u_csla (.x(ax), .y(ay), .s(as), .cout(aco));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_xfer) state_d = ADD;
            ADD:  state_d = carry_q ? CIN : (last ? DONE : ADD);
            CIN:  state_d = last ? DONE : ADD;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == ADD) || (state_q == CIN);
        out_valid = (state_q == DONE);
        ax        = '0;
        ay        = '0;
        case (state_q)
            ADD: begin
                ax = a_q[32*idx_q +: 32];
                ay = b_q[32*idx_q +: 32];
            end
            CIN: begin
                ax = tmp_q;
                ay = 32'd1;
            end
            default: ;
        endcase
    end

    // b is stored pre-inverted for subtract, so ADD never needs to know the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            tc_q    <= 1'b0;
            tmp_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_xfer) begin
                    a_q     <= a;
                    b_q     <= b ^ {W{sub_w}};
                    idx_q   <= '0;
                    carry_q <= sub_w;
                end
                ADD: begin
                    if (carry_q) begin
                        tmp_q <= as;
                        tc_q  <= aco;
                    end else begin
                        sum_q[32*idx_q +: 32] <= as;
                        carry_q <= aco;
                        if (last) cout_q <= aco;
                        else      idx_q  <= idx_q + IW'(1);
                    end
                end
                CIN: begin
                    sum_q[32*idx_q +: 32] <= as;
                    carry_q <= tc_q | aco;
                    if (last) cout_q <= tc_q | aco;
                    else      idx_q  <= idx_q + IW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_csla_mw_seq.sv
// Scoreboard bench for csla_mw_seq: queue of expected results from an arithmetic model, checked by a monitor.
module tb_csla_mw_seq;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;
    localparam int W1    = W + 1;

    logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready, cout, busy, sub_r;
    logic [W-1:0]  a, b, sum;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        int           lat;
        int           t0;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0, cyc = 0, or_mode = 0;
    bit   ov_prev = 0, exp_idle = 0;

    csla_mw_seq #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef CSLA_SEQ_SUB_EN
        .sub(sub_r),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input logic [W1-1:0] act, input logic [W1-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h @cyc %0d", nm, act, exp, cyc);
        end
    endtask

    // Result is full-width arithmetic; latency counts words whose incoming carry is 1.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic sb, input int t0);
        exp_t e;
        logic [W-1:0]  bb;
        logic [W1-1:0] full, part, mask;
        int n;
        bb   = sb ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bb} + W1'(sb);
        n = 0;
        for (int i = 0; i < WORDS; i++) begin
            mask = (W1'(1) << (32 * i)) - W1'(1);
            part = ({1'b0, av} & mask) + ({1'b0, bb} & mask) + W1'(sb);
            if (part[32*i]) n++;
        end
        e.sum = full[W-1:0];
        e.co  = full[W];
        e.lat = WORDS + n;
        e.t0  = t0;
        return e;
    endfunction

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            ov_prev  = 0;
            exp_idle = 0;
        end else begin
            if (exp_idle) begin
                chk("in_ready_after_hs", W1'(in_ready), W1'(1));
                exp_idle = 0;
            end
            if (out_valid) begin
                chk("in_ready_while_valid", W1'(in_ready), W1'(0));
                chk("busy_while_valid", W1'(busy), W1'(0));
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid got=1 want=0 @cyc %0d", cyc);
                end else begin
                    if (!ov_prev) chk("latency", W1'(cyc - q[0].t0 - 1), W1'(q[0].lat));
                    chk("sum", {1'b0, sum}, {1'b0, q[0].sum});
                    chk("cout", W1'(cout), W1'(q[0].co));
                    if (out_ready) begin
                        void'(q.pop_front());
                        exp_idle = 1;
                    end
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sb, input bit push);
        int n;
        @(negedge clk);
        a = av; b = bv; sub_r = sb; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got=0 want=1 @cyc %0d", cyc);
            in_valid = 1'b0;
            return;
        end
        if (push) q.push_back(model(av, bv, sb, cyc));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || !in_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d want=0 pending @cyc %0d", q.size(), cyc);
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++)
            v[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        return v;
    endfunction

    initial begin
        logic [W-1:0] ones;
        logic         sb;
        int           n;
        ones = '1;
        rst_n = 0; in_valid = 0; a = '0; b = '0; sub_r = 0; out_ready = 1;
        #12;
        chk("rst_in_ready", W1'(in_ready), W1'(1));
        chk("rst_out_valid", W1'(out_valid), W1'(0));
        chk("rst_busy", W1'(busy), W1'(0));
        chk("rst_sum", {1'b0, sum}, W1'(0));
        chk("rst_cout", W1'(cout), W1'(0));
        @(negedge clk);
        rst_n = 1;

        issue(W'(1), W'(2), 1'b0, 1'b1);
        drain();
        issue(ones, W'(1), 1'b0, 1'b1);
        drain();
        issue(ones, ones, 1'b0, 1'b1);
        drain();

        // Consumer stall: monitor re-checks the held result every cycle.
        or_mode = 2;
        issue(W'(3), ones, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached_valid", W1'(out_valid), W1'(1));
        repeat (5) @(negedge clk);
        or_mode = 0;
        drain();

        // Reset during CIN of word 2; this op must never produce output.
        issue(ones, W'(1), 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_op_busy", W1'(busy), W1'(1));
        rst_n = 0;
        #1;
        chk("abort_out_valid", W1'(out_valid), W1'(0));
        chk("abort_busy", W1'(busy), W1'(0));
        chk("abort_in_ready", W1'(in_ready), W1'(1));
        @(negedge clk);
        rst_n = 1;
        issue(W'(5), W'(7), 1'b0, 1'b1);
        drain();

`ifdef CSLA_SEQ_SUB_EN
        issue(W'(5), W'(7), 1'b1, 1'b1);
        drain();
        issue(W'(7), W'(5), 1'b1, 1'b1);
        drain();
`endif

        or_mode = 1;
        for (int i = 0; i < 1000; i++) begin
`ifdef CSLA_SEQ_SUB_EN
            sb = 1'($urandom_range(0, 1));
`else
            sb = 1'b0;
`endif
            issue(rnd_op(), rnd_op(), sb, 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        or_mode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
